// File: rtl/vend_dispense_ctrl.sv
// Actuator sequencer for the vending FSM: releases one drink, then pays the
// change one coin at a time, and records coins that could not be paid.
module vend_dispense_ctrl #(
    parameter int unsigned DRINK_CYC = 4,
    parameter int unsigned COIN_CYC  = 2,
    parameter int unsigned GAP_CYC   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] cd_in,
    input  logic       cd_valid,
    input  logic       coin_empty,
    output logic       ready,
    output logic       drink_fire,
    output logic [1:0] drink_sel,
    output logic       coin_fire,
    output logic       done,
    output logic [2:0] change_owed
);

    localparam int unsigned TW = 8;
    localparam int unsigned NW = 3;
    localparam logic [TW-1:0] DRINK_LD = TW'(DRINK_CYC - 1);
    localparam logic [TW-1:0] COIN_LD  = TW'(COIN_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRINK_ON  = 3'd1,
        DRINK_GAP = 3'd2,
        COIN_ON   = 3'd3,
        COIN_GAP  = 3'd4,
        DONE      = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NW-1:0] rem_q, rem_d;
    logic [1:0]    drink_sel_q, drink_sel_d;
    logic [NW-1:0] change_owed_q, change_owed_d;
    logic          ready_q, ready_d;
    logic          drink_fire_q, drink_fire_d;
    logic          coin_fire_q, coin_fire_d;
    logic          done_q, done_d;
    logic          decide;
    logic [NW-1:0] dec_rem;

    // State, timer, coin count and transaction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rem_q         <= '0;
            drink_sel_q   <= '0;
            change_owed_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rem_q         <= rem_d;
            drink_sel_q   <= drink_sel_d;
            change_owed_q <= change_owed_d;
        end
    end

    // Next state; the coin decision is resolved in the same cycle a phase ends
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rem_d         = rem_q;
        drink_sel_d   = drink_sel_q;
        change_owed_d = change_owed_q;
        decide        = 1'b0;
        dec_rem       = rem_q;

        case (state_q)
            IDLE: begin
                if (cd_valid && (cd_in != '0)) begin
                    rem_d         = cd_in[4:2];
                    drink_sel_d   = cd_in[1:0];
                    change_owed_d = '0;
                    if (cd_in[1:0] != 2'b00) begin
                        state_d = DRINK_ON;
                        timer_d = DRINK_LD;
                    end else begin
                        decide  = 1'b1;
                        dec_rem = cd_in[4:2];
                    end
                end
            end
            DRINK_ON: begin
                if (timer_q == '0) begin
                    state_d = DRINK_GAP;
                    timer_d = GAP_LD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DRINK_GAP: begin
                if (timer_q == '0) begin
                    decide = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            COIN_ON: begin
                if (timer_q == '0) begin
                    state_d = COIN_GAP;
                    timer_d = GAP_LD;
                    rem_d   = rem_q - NW'(1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            COIN_GAP: begin
                if (timer_q == '0) begin
                    decide = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (decide) begin
            if (dec_rem == '0) begin
                state_d = DONE;
            end else if (!coin_empty) begin
                state_d = COIN_ON;
                timer_d = COIN_LD;
            end else begin
                change_owed_d = dec_rem;
                state_d       = DONE;
            end
        end
    end

    // Output decode from the next state so the registered outputs align with it
    always_comb begin
        ready_d      = (state_d == IDLE);
        drink_fire_d = (state_d == DRINK_ON);
        coin_fire_d  = (state_d == COIN_ON);
        done_d       = (state_d == DONE);
    end

    // Registered actuator and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q      <= 1'b1;
            drink_fire_q <= 1'b0;
            coin_fire_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            drink_fire_q <= drink_fire_d;
            coin_fire_q  <= coin_fire_d;
            done_q       <= done_d;
        end
    end

    assign ready       = ready_q;
    assign drink_fire  = drink_fire_q;
    assign drink_sel   = drink_sel_q;
    assign coin_fire   = coin_fire_q;
    assign done        = done_q;
    assign change_owed = change_owed_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: a per-cycle expected output stream
// is queued from the request word and popped as the DUT runs.
module tb_vend_dispense_ctrl;

    localparam int DC = 4;
    localparam int CC = 2;
    localparam int GC = 3;

    typedef struct packed {
        logic       rdy;
        logic       dfire;
        logic       cfire;
        logic       dn;
        logic [1:0] sel;
        logic [2:0] owed;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] cd_in;
    logic       cd_valid;
    logic       coin_empty;
    logic       ready;
    logic       drink_fire;
    logic [1:0] drink_sel;
    logic       coin_fire;
    logic       done;
    logic [2:0] change_owed;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_sel  = 2'b00;
    logic [2:0] exp_owed = 3'b000;

    vend_dispense_ctrl #(.DRINK_CYC(DC), .COIN_CYC(CC), .GAP_CYC(GC)) dut (
        .clk        (clk),
        .reset      (reset),
        .cd_in      (cd_in),
        .cd_valid   (cd_valid),
        .coin_empty (coin_empty),
        .ready      (ready),
        .drink_fire (drink_fire),
        .drink_sel  (drink_sel),
        .coin_fire  (coin_fire),
        .done       (done),
        .change_owed(change_owed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stream for one request: drink phase, paid coins, done, back to idle
    task automatic push_expected(input logic [4:0] cd, input int n_paid);
        logic [2:0] ch;
        ch      = cd[4:2];
        exp_sel = cd[1:0];
        if (cd[1:0] != 2'b00) begin
            repeat (DC) exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, exp_sel, 3'b000});
            repeat (GC) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, exp_sel, 3'b000});
        end
        for (int i = 0; i < n_paid; i++) begin
            repeat (CC) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, exp_sel, 3'b000});
            repeat (GC) exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, exp_sel, 3'b000});
        end
        exp_owed = ch - 3'(n_paid);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, exp_sel, exp_owed});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, exp_sel, exp_owed});
    endtask

    // Drive one request and check every cycle until the stream drains
    task automatic run_txn(input logic [4:0] cd, input int n_paid, input int empty_at,
                           input int inject_at, input string name);
        int   guard;
        int   cyc;
        exp_t e;
        exp_t obs;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
            return;
        end
        push_expected(cd, n_paid);
        cd_in      = cd;
        cd_valid   = 1'b1;
        coin_empty = (empty_at == 0);
        cyc        = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e   = exp_q.pop_front();
            obs = {ready, drink_fire, coin_fire, done, drink_sel, change_owed};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s cycle %0d: got rdy/df/cf/dn/sel/owed=%b required %b",
                         name, cyc, obs, e);
            end
            if (cyc == 1) begin
                cd_valid = 1'b0;
                cd_in    = 5'b00000;
            end
            if (inject_at > 0 && cyc == inject_at) begin
                cd_valid = 1'b1;
                cd_in    = 5'b11111;
            end
            if (inject_at > 0 && cyc == inject_at + 1) begin
                cd_valid = 1'b0;
                cd_in    = 5'b00000;
            end
            if (empty_at > 0 && cyc == empty_at) coin_empty = 1'b1;
        end
        coin_empty = 1'b0;
        cd_valid   = 1'b0;
        cd_in      = 5'b00000;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset = 1'b0; cd_in = '0; cd_valid = 1'b0; coin_empty = 1'b0;
        #12;
        obs = {drink_fire, coin_fire, done, drink_sel, change_owed};
        total++;
        if (obs !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 00000000", obs);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b required 1", ready);
        end
        exp_sel  = 2'b00;
        exp_owed = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_drink_only();
        run_txn(5'b00011, 0, -1, -1, "drink_only");
    endtask

    task automatic test_full_refund();
        run_txn(5'b11100, 7, -1, -1, "full_refund");
    endtask

    task automatic test_drink_change();
        run_txn(5'b01010, 2, -1, -1, "drink_change");
    endtask

    task automatic test_hopper_empty();
        run_txn(5'b01100, 1, 3, -1, "hopper_empty");
    endtask

    // Zero request in idle is ignored; sticky owed and held selection survive it
    task automatic test_zero_request();
        exp_t e;
        exp_t obs;
        cd_in    = 5'b00000;
        cd_valid = 1'b1;
        repeat (5) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, exp_sel, exp_owed});
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {ready, drink_fire, coin_fire, done, drink_sel, change_owed};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL zero_request: got %b required %b", obs, e);
            end
        end
        cd_valid = 1'b0;
    endtask

    task automatic test_handshake();
        run_txn(5'b00101, 1, -1, 4, "handshake_busy");
    endtask

    task automatic test_empty_at_accept();
        run_txn(5'b01000, 0, 0, -1, "empty_no_drink");
        run_txn(5'b10101, 0, 0, -1, "empty_with_drink");
    endtask

    task automatic test_back_to_back();
        run_txn(5'b01111, 3, -1, -1, "b2b_first");
        run_txn(5'b00001, 0, -1, -1, "b2b_second");
    endtask

    // Reset dropped between edges while a coin pulse is active
    task automatic test_async_reset();
        exp_t e;
        exp_t obs;
        logic [5:0] mid;
        cd_in    = 5'b11100;
        cd_valid = 1'b1;
        @(negedge clk);
        cd_valid = 1'b0;
        cd_in    = 5'b00000;
        repeat (5) @(negedge clk);
        total++;
        if (coin_fire !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: coin_fire=%b required 1", coin_fire);
        end
        #2;
        reset = 1'b0;
        #1;
        mid = {drink_fire, coin_fire, done, change_owed};
        total++;
        if (mid !== 6'b000000) begin
            bad++;
            $display("FAIL async_drop: df/cf/dn/owed=%b required 000000", mid);
        end
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        exp_sel  = 2'b00;
        exp_owed = 3'b000;
        repeat (40) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000});
        while (exp_q.size() > 0) begin
            #1;
            e   = exp_q.pop_front();
            obs = {ready, drink_fire, coin_fire, done, drink_sel, change_owed};
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL async_after: got %b required %b", obs, e);
            end
            @(negedge clk);
        end
        run_txn(5'b00110, 1, -1, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_drink_only();
        test_full_refund();
        test_drink_change();
        test_hopper_empty();
        test_zero_request();
        test_handshake();
        test_empty_at_accept();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
